// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with 16x oversampled receiver,
// start-bit glitch filter, valid/ready hand-off and sticky error flags.
module uart_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 err_clr
);
  localparam int TX_DIV = CLK_HZ / BAUD;
  localparam int RX_RAW = CLK_HZ / (16 * BAUD);
  localparam int RX_DIV = (RX_RAW < 1) ? 1 : RX_RAW;
  localparam int TXW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RXW    = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               tx_st_q;
  logic [TXW-1:0]       tx_cnt_q;
  logic [4:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, tx_q, tx_ready_q, tx_wrap;

  assign tx_wrap  = (tx_cnt_q == TXW'(TX_DIV - 1));
  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      if (tx_st_q != S_IDLE) tx_cnt_q <= tx_wrap ? '0 : tx_cnt_q + TXW'(1);
      case (tx_st_q)
        S_IDLE: if (tx_valid && tx_ready_q) begin
          tx_shift_q <= tx_data;
          tx_par_q   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
          tx_q       <= 1'b0;
          tx_ready_q <= 1'b0;
          tx_cnt_q   <= '0;
          tx_st_q    <= S_START;
        end
        S_START: if (tx_wrap) begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= '0;
          tx_st_q    <= S_DATA;
        end
        S_DATA: if (tx_wrap) begin
          if (tx_bit_q == 5'(DATA_BITS - 1)) begin
            tx_bit_q <= '0;
            if (PARITY != 0) begin
              tx_q    <= tx_par_q;
              tx_st_q <= S_PARITY;
            end else begin
              tx_q    <= 1'b1;
              tx_st_q <= S_STOP;
            end
          end else begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 5'd1;
          end
        end
        S_PARITY: if (tx_wrap) begin
          tx_q    <= 1'b1;
          tx_st_q <= S_STOP;
        end
        S_STOP: if (tx_wrap) begin
          if (tx_bit_q == 5'(STOP_BITS - 1)) begin
            tx_ready_q <= 1'b1;
            tx_st_q    <= S_IDLE;
          end else begin
            tx_bit_q <= tx_bit_q + 5'd1;
          end
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic [RXW-1:0]       tick_q, tick_d;
  logic                 strobe, fall;
  state_e               rx_st_q;
  logic [3:0]           rx_scnt_q;
  logic [4:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
  logic                 rx_valid_q, rx_fe_q, rx_pe_q, rx_ov_q;

  assign strobe        = (tick_q == RXW'(RX_DIV - 1));
  assign fall          = (rx_st_q == S_IDLE) && rx_s3_q && !rx_s2_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_overrun    = rx_ov_q;

  always_comb begin
    tick_d = tick_q + RXW'(1);
    if (fall || strobe) tick_d = '0;
  end

  // Sync flops idle high so reset release never looks like a start edge.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      tick_q  <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      tick_q  <= tick_d;
    end
  end

  // Clear/consume first; FSM events later in the block take precedence.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= S_IDLE;
      rx_scnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_ov_q    <= 1'b0;
    end else begin
      if (err_clr) begin
        rx_fe_q <= 1'b0;
        rx_pe_q <= 1'b0;
        rx_ov_q <= 1'b0;
      end
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (rx_st_q)
        S_IDLE: if (fall) begin
          rx_scnt_q <= '0;
          rx_st_q   <= S_START;
        end
        S_START: if (strobe) begin
          if (rx_scnt_q == 4'd7) begin
            rx_scnt_q <= '0;
            rx_bit_q  <= '0;
            rx_st_q   <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_scnt_q <= rx_scnt_q + 4'd1;
          end
        end
        S_DATA: if (strobe) begin
          rx_scnt_q <= rx_scnt_q + 4'd1;
          if (rx_scnt_q == 4'hF) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == 5'(DATA_BITS - 1)) rx_st_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                               rx_bit_q <= rx_bit_q + 5'd1;
          end
        end
        S_PARITY: if (strobe) begin
          rx_scnt_q <= rx_scnt_q + 4'd1;
          if (rx_scnt_q == 4'hF) begin
            if ((^rx_shift_q ^ rx_s2_q) != (PARITY == 1)) rx_pe_q <= 1'b1;
            rx_st_q <= S_STOP;
          end
        end
        S_STOP: if (strobe) begin
          rx_scnt_q <= rx_scnt_q + 4'd1;
          if (rx_scnt_q == 4'hF) begin
            if (!rx_s2_q) rx_fe_q <= 1'b1;
            if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_ov_q <= 1'b1;
            end
            rx_st_q <= S_IDLE;
          end
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Directed + randomized bench for uart_core: three instances (8N1, 9E2
// loopback, 8O1) checked against a bit-list frame model.
module tb_uart_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] a_tx_data, a_rx_data;
  logic a_tx_valid, a_tx_ready, a_tx, a_rx, a_rx_valid, a_rx_ready, a_fe, a_pe, a_ov, a_clr;
  logic [8:0] b_tx_data, b_rx_data;
  logic b_tx_valid, b_tx_ready, b_tx, b_rx_valid, b_rx_ready, b_fe, b_pe, b_ov, b_clr;
  logic [7:0] c_tx_data, c_rx_data;
  logic c_tx_valid, c_tx_ready, c_tx, c_rx, c_rx_valid, c_rx_ready, c_fe, c_pe, c_ov, c_clr;

  uart_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk_50m(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov), .err_clr(a_clr));

  uart_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk_50m(clk), .rst_n(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx(b_tx), .rx(b_tx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov), .err_clr(b_clr));

  uart_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk_50m(clk), .rst_n(rst_n), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx(c_tx), .rx(c_rx), .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_frame_err(c_fe), .rx_parity_err(c_pe), .rx_overrun(c_ov), .err_clr(c_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as a bit list, LSB = first bit on the line.
  function automatic logic [31:0] mk_frame(input logic [15:0] d, input int db, input int par,
                                           input int stp, input bit flip_par, input bit stop_low,
                                           output int len);
    logic [31:0] f;
    int n;
    int ones;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) begin
      f[n] = 1'((par == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip_par;
      n++;
    end
    for (int s = 0; s < stp; s++) begin
      f[n] = 1'(!(s == 0 && stop_low));
      n++;
    end
    len = n;
    return f;
  endfunction

  function automatic logic sig(input int id);
    case (id)
      0:       return a_rx_valid;
      1:       return b_rx_valid;
      2:       return c_rx_valid;
      default: return b_tx_ready;
    endcase
  endfunction

  function automatic logic [31:0] rdata(input int w);
    case (w)
      0:       return {24'h0, a_rx_data};
      1:       return {23'h0, b_rx_data};
      default: return {24'h0, c_rx_data};
    endcase
  endfunction

  function automatic logic [2:0] flags(input int w);
    case (w)
      0:       return {a_ov, a_pe, a_fe};
      1:       return {b_ov, b_pe, b_fe};
      default: return {c_ov, c_pe, c_fe};
    endcase
  endfunction

  task automatic wait_sig(input int id, input string tag);
    int n;
    n = 0;
    while (sig(id) !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, sig(id), 1);
  endtask

  task automatic set_ready(input int w, input logic v);
    case (w)
      0:       a_rx_ready = v;
      1:       b_rx_ready = v;
      default: c_rx_ready = v;
    endcase
  endtask

  task automatic set_clr(input int w, input logic v);
    case (w)
      0:       a_clr = v;
      1:       b_clr = v;
      default: c_clr = v;
    endcase
  endtask

  task automatic consume(input int w, input string tag);
    @(negedge clk);
    set_ready(w, 1'b1);
    @(negedge clk);
    set_ready(w, 1'b0);
    chk({tag, "_consumed"}, sig(w), 0);
  endtask

  task automatic clear_flags(input int w, input string tag);
    @(negedge clk);
    set_clr(w, 1'b1);
    @(negedge clk);
    set_clr(w, 1'b0);
    chk({tag, "_cleared"}, flags(w), 0);
  endtask

  task automatic drive_rx(input int w, input logic [31:0] f, input int len);
    for (int i = 0; i < len; i++) begin
      if (w == 0) a_rx = f[i];
      else        c_rx = f[i];
      repeat (16) @(negedge clk);
    end
    if (w == 0) a_rx = 1'b1;
    else        c_rx = 1'b1;
  endtask

  task automatic rx_expect(input int w, input logic [31:0] d, input logic [2:0] fl, input string tag);
    wait_sig(w, tag);
    chk({tag, "_data"}, rdata(w), d);
    chk({tag, "_flags"}, flags(w), fl);
  endtask

  task automatic send_a(input logic [7:0] d, input string tag);
    logic [31:0] f;
    int len;
    f = mk_frame({8'h0, d}, 8, 0, 1, 1'b0, 1'b0, len);
    @(negedge clk);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    for (int i = 0; i < len * 16; i++) begin
      chk({tag, "_tx"}, a_tx, f[i/16]);
      chk({tag, "_rdy"}, a_tx_ready, 0);
      @(negedge clk);
    end
    chk({tag, "_rdy_end"}, a_tx_ready, 1);
    chk({tag, "_idle"}, a_tx, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f, f2, exp;
    int len, len2;
    logic [7:0] d8, e8;
    logic [8:0] d9;

    rst_n = 1'b0;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx = 1'b1; a_rx_ready = 1'b0; a_clr = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0; b_clr = 1'b0;
    c_tx_data = '0; c_tx_valid = 1'b0; c_rx = 1'b1; c_rx_ready = 1'b0; c_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_tx", a_tx, 1);
    chk("rst_tx_ready", a_tx_ready, 1);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_flags", flags(0), 0);
    chk("rst_b_valid", b_rx_valid, 0);
    chk("rst_c_tx", c_tx, 1);

    send_a(8'hA5, "tx_a5");
    for (int k = 0; k < 3; k++) send_a(8'($urandom), "tx_rand");

    // Back-to-back: valid held, one idle cycle between frames.
    d8 = 8'($urandom);
    e8 = 8'($urandom);
    f  = mk_frame({8'h0, d8}, 8, 0, 1, 1'b0, 1'b0, len);
    f2 = mk_frame({8'h0, e8}, 8, 0, 1, 1'b0, 1'b0, len2);
    @(negedge clk);
    a_tx_data  = d8;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_data = e8;
    for (int i = 0; i < 321; i++) begin
      if (i < 160)       exp = {31'h0, f[i/16]};
      else if (i == 160) exp = 1;
      else               exp = {31'h0, f2[(i-161)/16]};
      chk("b2b_tx", a_tx, exp);
      if (i == 160) chk("b2b_rdy_gap", a_tx_ready, 1);
      if (i == 161) begin
        chk("b2b_rdy_taken", a_tx_ready, 0);
        a_tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_rdy_end", a_tx_ready, 1);

    for (int k = 0; k < 3; k++) begin
      d9 = (k == 0) ? 9'h1C3 : 9'($urandom);
      @(negedge clk);
      b_tx_data  = d9;
      b_tx_valid = 1'b1;
      @(negedge clk);
      b_tx_valid = 1'b0;
      rx_expect(1, {23'h0, d9}, 3'b000, "loop");
      consume(1, "loop");
      wait_sig(3, "loop_txdone");
    end

    @(negedge clk);
    a_rx = 1'b0;
    repeat (4) @(negedge clk);
    a_rx = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk("glitch_novalid", a_rx_valid, 0);
      @(negedge clk);
    end
    chk("glitch_flags", flags(0), 0);
    f = mk_frame(16'h3C, 8, 0, 1, 1'b0, 1'b0, len);
    drive_rx(0, f, len);
    rx_expect(0, 32'h3C, 3'b000, "post_glitch");
    consume(0, "post_glitch");

    f = mk_frame(16'h55, 8, 0, 1, 1'b0, 1'b1, len);
    drive_rx(0, f, len);
    repeat (4) @(negedge clk);
    rx_expect(0, 32'h55, 3'b001, "frame_err");
    consume(0, "frame_err");
    clear_flags(0, "frame_err");

    d8 = 8'($urandom);
    f = mk_frame({8'h0, d8}, 8, 1, 1, 1'b0, 1'b0, len);
    drive_rx(2, f, len);
    rx_expect(2, {24'h0, d8}, 3'b000, "odd_ok");
    consume(2, "odd_ok");
    f = mk_frame(16'h01, 8, 1, 1, 1'b1, 1'b0, len);
    drive_rx(2, f, len);
    rx_expect(2, 32'h01, 3'b010, "parity_err");
    consume(2, "parity_err");
    clear_flags(2, "parity_err");

    f = mk_frame(16'h11, 8, 0, 1, 1'b0, 1'b0, len);
    drive_rx(0, f, len);
    repeat (4) @(negedge clk);
    f = mk_frame(16'h22, 8, 0, 1, 1'b0, 1'b0, len);
    drive_rx(0, f, len);
    repeat (20) @(negedge clk);
    chk("overrun_valid", a_rx_valid, 1);
    chk("overrun_data", a_rx_data, 32'h11);
    chk("overrun_flags", flags(0), 3'b100);
    consume(0, "overrun");
    clear_flags(0, "overrun");

    for (int k = 0; k < 3; k++) begin
      d8 = 8'($urandom);
      f = mk_frame({8'h0, d8}, 8, 0, 1, 1'b0, 1'b0, len);
      drive_rx(0, f, len);
      rx_expect(0, {24'h0, d8}, 3'b000, "rx_rand");
      consume(0, "rx_rand");
    end

    // Abort a TX frame inside data bit 3 (bit 3 forced 0 so the line is low).
    d8 = 8'($urandom) & 8'hF7;
    @(negedge clk);
    a_tx_data  = d8;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("rst_mid_pre", a_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_tx", a_tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", a_tx_ready, 1);
    chk("rst_mid_tx", a_tx, 1);
    send_a(8'($urandom), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART core and the next generation of the fixed-format 50 MHz UART. Clock rate, baud rate, data width, parity and stop-bit count are parameters. The receiver uses 16x oversampling with a start-bit glitch filter. Both directions use valid/ready handshakes, and the core reports framing, parity and overrun errors. It sits between on-chip logic and the FPGA serial pins, and it replaces the separate baud generator, transmitter and receiver instances.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bits per second.
- DATA_BITS, 8: payload bits per frame; legal range 5..16.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- Derived: TX_DIV = CLK_HZ/BAUD (integer floor); RX_DIV = CLK_HZ/(16*BAUD) (floor, minimum 1).

Ports:
- clk_50m  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  core can accept a word.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous to clk_50m.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer takes rx_data.
- rx_frame_err  out  1  sticky: a stop bit was sampled low.
- rx_parity_err  out  1  sticky: parity mismatch.
- rx_overrun  out  1  sticky: a frame completed while rx_valid was high.
- err_clr  in  1  clears all three sticky flags.

## Operation
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, both FSMs in IDLE, all counters 0.
- Frame format:
  - start bit (0);
  - DATA_BITS data bits, LSB first;
  - parity bit if PARITY≠0 (odd: total ones over data+parity is odd; even: total is even);
  - STOP_BITS stop bits (1).
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A word is accepted on any cycle with tx_valid & tx_ready. The word is latched and tx_ready drops the next cycle.
  - A per-bit counter counts 0..TX_DIV-1. Each state advances when the counter wraps.
  - DATA runs for DATA_BITS bits. PARITY is skipped when PARITY=0. STOP lasts STOP_BITS bit times.
  - At the end of the last stop bit the FSM returns to IDLE and tx_ready rises.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - A tick counter produces a 1-cycle oversample strobe every RX_DIV cycles. It free-runs and restarts at 0 on start detection.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised falling edge moves the FSM to START.
  - START: the line is resampled after 8 strobes (mid-bit). If it is high, the event is a glitch and the FSM returns to IDLE with no flags set. If it is low, the FSM proceeds.
  - Every later bit is sampled after 16 strobes (mid-bit) and shifted in LSB first.
  - PARITY state: a mismatch sets rx_parity_err.
  - STOP: only the first stop bit is checked. If it is low, rx_frame_err is set. A break (line held low) therefore yields data 0 plus a frame error.
  - After the stop sample the FSM returns to IDLE at once. A falling edge in the second stop bit or later starts a new frame.
- RX hand-off (single-entry holding register):
  - At the stop sample, if rx_valid=0: rx_data is loaded and rx_valid=1. The word is delivered even if it has a frame or parity error.
  - If rx_valid=1: the new word is dropped, rx_data is kept and rx_overrun=1.
  - rx_valid & rx_ready clears rx_valid the next cycle.
  - If completion and consumption happen in the same cycle, the new word is loaded, rx_valid stays 1 and no overrun is flagged.
- Error flags: err_clr clears all sticky flags. If err_clr coincides with a new error event, the set wins.
- Reset mid-frame: both FSMs abort, tx goes high asynchronously and any partial RX word is discarded.

## Timing
- TX latency: start bit appears on tx the cycle after acceptance.
- TX bit length: each bit lasts exactly TX_DIV cycles.
- TX frame length: (1+DATA_BITS+(PARITY≠0)+STOP_BITS)·TX_DIV cycles.
- TX back-to-back: tx_ready is high for one cycle after the frame. If tx_valid is held high, the next start bit follows the last stop bit with exactly 1 idle cycle.
- RX latency: rx_valid rises 1 cycle after the mid-stop-bit sample. Sync delay is 2 cycles.
- RX tolerance: sample point error of at most ±1 strobe; the receiver tolerates ±3% baud mismatch.

## Test plan
Parameters: CLK_HZ=1_600_000, BAUD=100_000, so TX_DIV=16 and RX_DIV=1.
- TX 8N1: send 0xA5 → tx line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_ready low for 160 cycles.
- Loopback (tx→rx), DATA_BITS=9, PARITY=2, STOP_BITS=2: send 0x1C3 → rx_valid with rx_data=0x1C3; no error flags.
- Glitch: rx low for 4 cycles then high → no rx_valid, FSM back in IDLE, no flags. A valid 0x3C frame driven on rx immediately afterwards is received correctly.
- Errors:
  - Frame 0x55 with stop bit forced low → rx_data=0x55, rx_frame_err=1.
  - Odd-parity frame 0x01 with parity bit 1 → rx_parity_err=1.
  - err_clr → all flags 0.
- Overrun: two frames 0x11 then 0x22 with rx_ready held low → rx_data=0x11, rx_overrun=1. Then rx_ready for one cycle → rx_valid=0.
- Reset mid-frame: assert rst_n=0 during data bit 3 of a TX frame → tx=1 immediately, tx_ready=1 after release, and the next word sends cleanly.
